// File: rtl/esm_pkg.sv
// Shared definitions for the ESM issue window: instruction field positions, width helpers
// and the window entry record.
package esm_pkg;

  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;

  // Entry fields are sized for the largest supported configuration; narrower instances
  // zero-extend into them and the unused upper bits are optimised away.
  localparam int unsigned INSTR_MAX_W = 64;
  localparam int unsigned REG_MAX_W   = 8;
  localparam int unsigned TAG_MAX_W   = 8;

  function automatic int unsigned reg_w(input int unsigned regnum);
    return (regnum > 1) ? $clog2(regnum) : 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned bs);
    return (bs > 1) ? $clog2(bs) : 1;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic                   issued;
    logic                   regwrite;
    logic [REG_MAX_W-1:0]   rd;
    logic [TAG_MAX_W-1:0]   src1_tag;
    logic                   src1_pend;
    logic [TAG_MAX_W-1:0]   src2_tag;
    logic                   src2_pend;
    logic [INSTR_MAX_W-1:0] instr;
  } esm_entry_t;

endpackage

// File: rtl/esm_find_first.sv
// Lowest-set-bit encoder with a found flag.
module esm_find_first #(
  parameter  int unsigned N = 16,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downwards so the lowest requesting bit is written last.
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        found = 1'b1;
        idx   = W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/esm_issue_window.sv
// ESM issue window: holds BS decoded instructions, tracks RAW hazards through a per-register
// producer table and issues the lowest ready entry; entries retire on writeback.
module esm_issue_window
  import esm_pkg::*;
#(
  parameter  int unsigned INSTR_W = 32,
  parameter  int unsigned REGNUM  = 32,
  parameter  int unsigned BS      = 16,
  localparam int unsigned REG_W   = reg_w(REGNUM),
  localparam int unsigned IDX_W   = idx_w(BS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_alusrc,
  input  logic               in_regwrite,
  output logic [IDX_W-1:0]   in_index,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [IDX_W-1:0]   iss_index,
  output logic [INSTR_W-1:0] iss_instr,
  input  logic               wb_valid,
  input  logic [IDX_W-1:0]   wb_index,
  output logic [IDX_W:0]     occupancy,
  output logic               empty
);

  esm_entry_t         ent_q    [BS];
  logic [REGNUM-1:0]  pvalid_q;
  logic [IDX_W-1:0]   ptag_q   [REGNUM];
  logic [IDX_W:0]     count_q;

  logic [REG_W-1:0]   in_rd, in_rs1, in_rs2;
  logic [BS-1:0]      free_vec, cand_vec;
  logic               free_found;
  logic               dispatch, iss_fire, wb_fire;
  esm_entry_t         new_entry;
  logic               unused_entry_bits;

  assign in_rd  = in_instr[RD_LSB  +: REG_W];
  assign in_rs1 = in_instr[RS1_LSB +: REG_W];
  assign in_rs2 = in_instr[RS2_LSB +: REG_W];

  always_comb begin
    free_vec = '0;
    cand_vec = '0;
    for (int unsigned i = 0; i < BS; i++) begin
      free_vec[i] = !ent_q[i].valid;
      cand_vec[i] = ent_q[i].valid && !ent_q[i].issued &&
                    !ent_q[i].src1_pend && !ent_q[i].src2_pend;
    end
  end

  esm_find_first #(.N(BS)) u_alloc (
    .req   (free_vec),
    .found (free_found),
    .idx   (in_index)
  );

  esm_find_first #(.N(BS)) u_select (
    .req   (cand_vec),
    .found (iss_valid),
    .idx   (iss_index)
  );

  assign in_ready  = free_found && !flush;
  assign dispatch  = in_valid && in_ready;
  assign iss_fire  = iss_valid && iss_ready;
  // Writebacks to slots that are not resident and issued are dropped.
  assign wb_fire   = wb_valid && ent_q[wb_index].valid && ent_q[wb_index].issued;
  assign iss_instr = ent_q[iss_index].instr[INSTR_W-1:0];
  assign occupancy = count_q;
  assign empty     = (count_q == '0);

  // A producer completing in the dispatch cycle is bypassed so the reader never waits on it.
  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.regwrite  = in_regwrite;
    new_entry.rd        = REG_MAX_W'(in_rd);
    new_entry.src1_tag  = TAG_MAX_W'(ptag_q[in_rs1]);
    new_entry.src1_pend = (in_rs1 != '0) && pvalid_q[in_rs1] &&
                          !(wb_fire && (wb_index == ptag_q[in_rs1]));
    new_entry.src2_tag  = TAG_MAX_W'(ptag_q[in_rs2]);
    new_entry.src2_pend = !in_alusrc && (in_rs2 != '0) && pvalid_q[in_rs2] &&
                          !(wb_fire && (wb_index == ptag_q[in_rs2]));
    new_entry.instr     = INSTR_MAX_W'(in_instr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BS; i++) ent_q[i] <= '0;
      for (int unsigned r = 0; r < REGNUM; r++) ptag_q[r] <= '0;
      pvalid_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < BS; i++) ent_q[i] <= '0;
      for (int unsigned r = 0; r < REGNUM; r++) ptag_q[r] <= '0;
      pvalid_q <= '0;
      count_q  <= '0;
    end else begin
      if (wb_fire) begin
        for (int unsigned i = 0; i < BS; i++) begin
          if (ent_q[i].src1_tag == TAG_MAX_W'(wb_index)) ent_q[i].src1_pend <= 1'b0;
          if (ent_q[i].src2_tag == TAG_MAX_W'(wb_index)) ent_q[i].src2_pend <= 1'b0;
        end
        ent_q[wb_index].valid <= 1'b0;
        for (int unsigned r = 0; r < REGNUM; r++) begin
          if (pvalid_q[r] && (ptag_q[r] == wb_index)) pvalid_q[r] <= 1'b0;
        end
      end
      if (iss_fire) ent_q[iss_index].issued <= 1'b1;
      // The allocated slot is always free, so this never collides with the wb/issue slots;
      // a new producer for a register also overrides the wb clear of its previous producer.
      if (dispatch) begin
        ent_q[in_index] <= new_entry;
        if (in_regwrite && (in_rd != '0)) begin
          pvalid_q[in_rd] <= 1'b1;
          ptag_q[in_rd]   <= in_index;
        end
      end
      case ({dispatch, wb_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    unused_entry_bits = 1'b0;
    for (int unsigned i = 0; i < BS; i++) unused_entry_bits = unused_entry_bits ^ (^ent_q[i]);
  end

endmodule
